// File: rtl/shift_sequencer.sv
// Iterative SLL/SRL/SRA execution unit shifting STEP bits per cycle beside the ALU.
// Optional macro SHIFT_SEQ_PERF_EN adds a saturating busy-cycle counter port.
module shift_sequencer #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      ALUControl,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [4:0]      shamt,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
`ifdef SHIFT_SEQ_PERF_EN
    ,
    output logic [31:0]     perf_busy_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL,
        OP_SRL,
        OP_SRA
    } op_e;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rem_q, rem_d;

    logic            accept;
    logic [4:0]      step_amt;
    logic [4:0]      rem_left;
    logic [XLEN-1:0] shifted;

    assign ready  = (state_q != S_SHIFT);
    assign busy   = (state_q == S_SHIFT);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

    assign accept = start && ready && (ALUControl == 3'b111) &&
                    ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Last iteration may be shorter than STEP so the total never overshoots shamt.
    assign step_amt = (rem_q < STEP_W) ? rem_q : STEP_W;
    assign rem_left = rem_q - step_amt;

    always_comb begin
        shifted = data_q >> step_amt;
        case (op_q)
            OP_SLL:  shifted = data_q << step_amt;
            OP_SRA:  shifted = $signed(data_q) >>> step_amt;
            default: shifted = data_q >> step_amt;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        rem_d    = rem_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    data_d = shifted;
                    rem_d  = rem_left;
                    if (rem_left == 5'd0) begin
                        result_d = shifted;
                        state_d  = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        data_d = src_a;
                        rem_d  = shamt;
                        if (funct3 == 3'b001) begin
                            op_d = OP_SLL;
                        end else if (funct7_5) begin
                            op_d = OP_SRA;
                        end else begin
                            op_d = OP_SRL;
                        end
                        if (shamt == 5'd0) begin
                            result_d = src_a;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            data_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

`ifdef SHIFT_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    assign perf_d           = (busy && (perf_q != 32'hFFFF_FFFF)) ? perf_q + 32'd1 : perf_q;
    assign perf_busy_cycles = perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end
`endif

endmodule
